// File: rtl/bsg_link_packet_concentrator.sv
// Packet-aware N:1 ready-and concentrator: arbitrates headers, locks onto the
// granted channel for the body flits, and buffers the merged stream in a 2-entry FIFO.
//
// state  | meaning
// IDLE   | arbitrate among valid channels for the next header flit
// LOCKED | forward body flits of the granted channel only

module bsg_link_packet_concentrator #(
   parameter  int flit_width_p = 64,
   parameter  int num_in_p     = 3,
   parameter  int len_width_p  = 4,
   parameter  int arb_mode_p   = 0,
   localparam int cid_width_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1
) (
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic [num_in_p-1:0]              v_i,
   input  logic [num_in_p*flit_width_p-1:0] data_i,
   output logic [num_in_p-1:0]              ready_and_o,
   output logic                             v_o,
   output logic [flit_width_p-1:0]          data_o,
   output logic [cid_width_lp-1:0]          cid_o,
   input  logic                             ready_and_i,
   output logic                             locked_o,
   output logic [cid_width_lp-1:0]          grant_o
);

   typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

   localparam int entry_width_lp = cid_width_lp + flit_width_p;

   state_t                    r_state, w_state_nxt;
   logic [cid_width_lp-1:0]   r_rr_ptr, r_grant;
   logic [cid_width_lp-1:0]   w_winner, w_sel, w_rr_nxt;
   logic [len_width_p-1:0]    r_remaining, w_len;
   logic [num_in_p-1:0]       w_ready;
   logic [flit_width_p-1:0]   w_flit;
   logic                      w_any_v, w_push, w_pop, w_space;

   logic [entry_width_lp-1:0] r_mem [2];
   logic                      r_wr_ptr, r_rd_ptr;
   logic [1:0]                r_count;

   // Output FIFO; a full FIFO still takes a flit when the head leaves this cycle.
   assign w_pop            = v_o & ready_and_i;
   assign w_space          = (r_count != 2'd2) | w_pop;
   assign v_o              = (r_count != 2'd0);
   assign {cid_o, data_o}  = r_mem[r_rd_ptr];

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {w_sel, w_flit};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   // Scanning downward lets the lowest offset from the start point win.
   always_comb begin : p_arb
      int idx;
      idx      = 0;
      w_winner = '0;
      if (arb_mode_p == 1) begin
         for (int i = num_in_p - 1; i >= 0; i--) begin
            if (v_i[i]) begin
               w_winner = cid_width_lp'(i);
            end
         end
      end else begin
         for (int off = num_in_p - 1; off >= 0; off--) begin
            idx = int'(r_rr_ptr) + off;
            if (idx >= num_in_p) begin
               idx = idx - num_in_p;
            end
            if (v_i[idx]) begin
               w_winner = cid_width_lp'(idx);
            end
         end
      end
   end

   assign w_any_v  = |v_i;
   assign w_rr_nxt = (w_winner == cid_width_lp'(num_in_p - 1)) ? '0
                                                               : w_winner + cid_width_lp'(1);

   always_comb begin : p_ready
      w_sel   = r_grant;
      w_ready = '0;
      unique case (r_state)
         ST_IDLE: begin
            w_sel = w_winner;
            if (w_any_v) begin
               w_ready[w_winner] = w_space;
            end
         end
         ST_LOCKED: begin
            w_ready[r_grant] = w_space;
         end
         default: begin
            w_ready = '0;
         end
      endcase
   end

   assign ready_and_o = reset_n_i ? w_ready : '0;
   assign w_push      = |(v_i & ready_and_o);
   assign w_flit      = data_i[int'(w_sel)*flit_width_p +: flit_width_p];
   assign w_len       = w_flit[len_width_p-1:0];

   always_comb begin : p_next
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_push && (w_len != '0)) begin
               w_state_nxt = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (w_push && (r_remaining == len_width_p'(1))) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_state     <= ST_IDLE;
         r_rr_ptr    <= '0;
         r_grant     <= '0;
         r_remaining <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_push) begin
            if (r_state == ST_IDLE) begin
               r_grant     <= w_winner;
               r_rr_ptr    <= w_rr_nxt;
               r_remaining <= w_len;
            end else begin
               r_remaining <= r_remaining - len_width_p'(1);
            end
         end
      end
   end

   assign locked_o = (r_state == ST_LOCKED);
   assign grant_o  = r_grant;

   ap_num_in : assert property (@(posedge clk_i) num_in_p >= 2);

   ap_hold : assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (v_o && !ready_and_i) |=> (v_o && $stable(data_o) && $stable(cid_o)));

endmodule

// File: tb/tb_bsg_link_packet_concentrator.sv
// Randomized bench: a packet-level model predicts ready/locked/grant each cycle and
// a scoreboard checks the merged output stream; a second instance covers fixed priority.

module tb_bsg_link_packet_concentrator;

   localparam int FW = 64;
   localparam int N  = 3;
   localparam int LW = 4;
   localparam int CW = 2;
   localparam logic [FW-1:0] FP0 = 64'hC0C0_1234_5678_9AA0;
   localparam logic [FW-1:0] FP2 = 64'hC2C2_8765_4321_0BB0;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [N-1:0]  v_i;
   logic [N*FW-1:0] data_i;
   logic [N-1:0]  ready_and_o;
   logic          v_o;
   logic [FW-1:0] data_o;
   logic [CW-1:0] cid_o;
   logic          ready_and_i;
   logic          locked_o;
   logic [CW-1:0] grant_o;

   logic [N-1:0]    fp_v_i;
   logic [N*FW-1:0] fp_data_i;
   logic [N-1:0]    fp_ready_and_o;
   logic            fp_v_o;
   logic [FW-1:0]   fp_data_o;
   logic [CW-1:0]   fp_cid_o;
   logic            fp_ready_and_i;
   logic            fp_locked_o;
   logic [CW-1:0]   fp_grant_o;

   always #5 clk = ~clk;

   bsg_link_packet_concentrator #(.flit_width_p(FW), .num_in_p(N), .len_width_p(LW),
                                  .arb_mode_p(0)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .data_i(data_i),
      .ready_and_o(ready_and_o), .v_o(v_o), .data_o(data_o), .cid_o(cid_o),
      .ready_and_i(ready_and_i), .locked_o(locked_o), .grant_o(grant_o));

   bsg_link_packet_concentrator #(.flit_width_p(FW), .num_in_p(N), .len_width_p(LW),
                                  .arb_mode_p(1)) dut_fp (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(fp_v_i), .data_i(fp_data_i),
      .ready_and_o(fp_ready_and_o), .v_o(fp_v_o), .data_o(fp_data_o), .cid_o(fp_cid_o),
      .ready_and_i(fp_ready_and_i), .locked_o(fp_locked_o), .grant_o(fp_grant_o));

   typedef struct packed {
      logic [CW-1:0] cid;
      logic [FW-1:0] flit;
   } ent_t;

   logic [FW-1:0] chq [N][$];
   ent_t          exp_q [$];

   int occ, m_grant, m_rr, m_rem;
   bit m_locked, fp_en;
   int p_valid, p_ready, p_newpkt, max_len;
   int acc_cnt [N];
   int n_checks, n_pass;

   task automatic check(input bit ok, input string name,
                        input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic int rr_winner(input logic [N-1:0] v, input int rr);
      for (int off = 0; off < N; off++) begin
         int ch;
         ch = (rr + off) % N;
         if (v[ch]) return ch;
      end
      return -1;
   endfunction

   task automatic gen_pkt(input int ch, input int len);
      logic [FW-1:0] f;
      f = {$urandom, $urandom};
      f[LW-1:0] = LW'(len);
      chq[ch].push_back(f);
      for (int b = 0; b < len; b++) chq[ch].push_back({$urandom, $urandom});
   endtask

   task automatic drive();
      for (int k = 0; k < N; k++) begin
         if (chq[k].size() == 0 && ($urandom % 100) < p_newpkt)
            gen_pkt(k, $urandom_range(0, max_len));
         v_i[k] = (chq[k].size() > 0) && (($urandom % 100) < p_valid);
         data_i[k*FW +: FW] = (chq[k].size() > 0) ? chq[k][0] : {$urandom, $urandom};
      end
      ready_and_i = reset_n && (($urandom % 100) < p_ready);
   endtask

   // One clock: model check/update at the falling edge, new stimulus just after rise.
   task automatic step();
      logic [N-1:0]  exp_rdy, acc;
      logic [FW-1:0] f;
      bit            pop_m, space;
      int            w;
      @(negedge clk);
      if (!reset_n) begin
         check(ready_and_o == '0, "ready_in_reset", ready_and_o, 0);
         occ = 0; m_locked = 0; m_rr = 0; m_grant = 0; m_rem = 0;
         exp_q.delete();
         for (int k = 0; k < N; k++) chq[k].delete();
      end else begin
         pop_m = (occ > 0) && ready_and_i;
         space = (occ < 2) || pop_m;
         check(v_o == (occ > 0), "v_o", v_o, occ > 0);
         check(locked_o == m_locked, "locked_o", locked_o, m_locked);
         check(grant_o == CW'(m_grant), "grant_o", grant_o, m_grant);
         exp_rdy = '0;
         if (m_locked) begin
            if (space) exp_rdy[m_grant] = 1'b1;
         end else begin
            w = rr_winner(v_i, m_rr);
            if (w >= 0 && space) exp_rdy[w] = 1'b1;
         end
         check(ready_and_o == exp_rdy, "ready_and_o", ready_and_o, exp_rdy);
         acc = v_i & ready_and_o;
         for (int k = 0; k < N; k++) begin
            if (acc[k] && chq[k].size() > 0) begin
               f = chq[k].pop_front();
               exp_q.push_back({CW'(k), f});
               acc_cnt[k]++;
               if (!m_locked) begin
                  m_grant = k;
                  m_rr    = (k + 1) % N;
                  if (f[LW-1:0] != '0) begin
                     m_locked = 1;
                     m_rem    = int'(f[LW-1:0]);
                  end
               end else begin
                  m_rem--;
                  if (m_rem == 0) m_locked = 0;
               end
            end
         end
         occ = occ + $countones(acc) - int'(pop_m);
      end
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic drain();
      bit done;
      p_newpkt = 0; p_valid = 100; p_ready = 100;
      drive();
      done = 0;
      for (int c = 0; c < 300 && !done; c++) begin
         step();
         done = (exp_q.size() == 0) && (occ == 0) && !m_locked &&
                (chq[0].size() + chq[1].size() + chq[2].size() == 0);
      end
      check(done, "drain", exp_q.size(), 0);
   endtask

   task automatic clr_cnt();
      for (int k = 0; k < N; k++) acc_cnt[k] = 0;
   endtask

   // Scoreboard: every output transfer must match the oldest accepted flit.
   always @(negedge clk) begin
      ent_t e;
      if (reset_n && v_o && ready_and_i) begin
         if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_output", {cid_o, data_o}, 0);
         end else begin
            e = exp_q.pop_front();
            check({cid_o, data_o} == e, "out_flit", {cid_o, data_o}, e);
         end
      end
   end

   // Fixed-priority instance: channels 0 and 2 always valid, channel 0 must always win.
   always @(negedge clk) begin
      if (fp_en && reset_n) begin
         check(fp_ready_and_o == 3'b001, "fp_ready", fp_ready_and_o, 3'b001);
         if (fp_v_o)
            check({fp_cid_o, fp_data_o} == {2'd0, FP0}, "fp_out",
                  {fp_cid_o, fp_data_o}, {2'd0, FP0});
      end
   end

   initial begin
      bit found;
      n_checks = 0; n_pass = 0; fp_en = 0;
      p_valid = 0; p_ready = 0; p_newpkt = 0; max_len = 0;
      reset_n = 1'b0; v_i = '0; data_i = '0; ready_and_i = 1'b0;
      fp_v_i = 3'b101; fp_data_i = {FP2, 64'h0, FP0}; fp_ready_and_i = 1'b1;
      clr_cnt();
      repeat (3) step();
      reset_n = 1'b1;
      fp_en = 1;
      drive();

      // single len=0 header on channel 1
      p_valid = 100; p_ready = 100;
      chq[1].push_back(64'h1111_2222_3333_44A0);
      drive();
      drain();

      // round-robin fairness with all channels streaming len=0 headers
      p_newpkt = 100; max_len = 0; p_valid = 100; p_ready = 100;
      drive();
      clr_cnt();
      repeat (30) step();
      for (int k = 0; k < N; k++) check(acc_cnt[k] == 10, "rr_share", acc_cnt[k], 10);
      drain();

      // back-pressure: only two flits fit while downstream is stalled
      for (int i = 0; i < 6; i++) gen_pkt(1, 0);
      p_ready = 0; p_valid = 100;
      drive();
      clr_cnt();
      repeat (10) step();
      check(acc_cnt[1] == 2, "stall_accepts", acc_cnt[1], 2);
      drain();

      // reset in LOCKED with two body flits outstanding
      gen_pkt(0, 5);
      p_valid = 100; p_ready = 100;
      drive();
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         step();
         found = m_locked && (m_rem == 2);
      end
      check(found, "reach_rem2", found, 1);
      reset_n = 1'b0;
      drive();
      step();
      reset_n = 1'b1;
      drive();
      step();
      check(v_o == 1'b0 && locked_o == 1'b0 && grant_o == '0, "post_reset",
            {v_o, locked_o, grant_o}, 0);
      chq[2].push_back(64'h2222_0000_0000_00B0);
      drive();
      drain();

      // channel 0 packet with 3 bodies must not be split by a waiting channel 2
      gen_pkt(0, 3);
      gen_pkt(2, 0);
      drive();
      drain();

      // random traffic, short packets then full length range
      p_valid = 70; p_ready = 60; p_newpkt = 40; max_len = 4;
      drive();
      repeat (600) step();
      drain();
      p_valid = 80; p_ready = 80; p_newpkt = 50; max_len = (1 << LW) - 1;
      drive();
      repeat (400) step();
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
